// File: rtl/spi_slave_link.sv
// spi_slave_link: SPI mode-0 slave byte engine, fully fclk-oversampled.
// Deserializes MOSI into rx strobes, serializes a tx byte stream on MISO.
module spi_slave_link #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       spics_n,
  input  logic       spick,
  input  logic       spido,
  output logic       spidi,
  output logic [7:0] rx_data,
  output logic       rx_stb,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_need,
  output logic       tx_underrun,
  output logic       frame_end,
  output logic       busy
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] ck_sync;
  logic [SYNC_STAGES-1:0] do_sync;
  logic cs_s, ck_s, do_s;
  logic cs_d, ck_d;

  logic [7:0] txsh;
  logic [7:0] rxsh;
  logic [7:0] tx_hold;
  logic       tx_valid;
  logic [2:0] bitcnt;
  logic       first_flag;
  logic       stb_pend;

  logic cs_fall, cs_rise, cs_act;
  logic ck_rise, ck_fall;
  logic do_load;
  logic [7:0] ld_byte;
  logic       ld_under;

  assign cs_s = cs_sync[SYNC_STAGES-1];
  assign ck_s = ck_sync[SYNC_STAGES-1];
  assign do_s = do_sync[SYNC_STAGES-1];

  // CS must be low in both compared samples, so a CS edge always
  // beats a coincident spick edge.
  assign cs_fall = cs_d & ~cs_s;
  assign cs_rise = ~cs_d & cs_s;
  assign cs_act  = ~cs_d & ~cs_s;
  assign ck_rise = cs_act & ck_s & ~ck_d;
  assign ck_fall = cs_act & ~ck_s & ck_d;
  assign do_load = cs_fall | (ck_fall & (bitcnt == 3'd0));

  assign spidi = busy ? txsh[7] : 1'b1;

  // Next shift-out byte: same-cycle write bypasses the holding register.
  always_comb begin
    ld_byte  = IDLE_BYTE;
    ld_under = 1'b1;
    if (tx_wr) begin
      ld_byte  = tx_data;
      ld_under = 1'b0;
    end else if (tx_valid) begin
      ld_byte  = tx_hold;
      ld_under = 1'b0;
    end
  end

  // Pin synchronizers plus one delayed sample for edge detection.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync <= '1;
      ck_sync <= '0;
      do_sync <= '0;
      cs_d    <= 1'b1;
      ck_d    <= 1'b0;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], spics_n};
      ck_sync <= {ck_sync[SYNC_STAGES-2:0], spick};
      do_sync <= {do_sync[SYNC_STAGES-2:0], spido};
      cs_d    <= cs_s;
      ck_d    <= ck_s;
    end
  end

  // Holding register: writes outside a load park the byte here.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_hold  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (do_load) begin
      tx_valid <= 1'b0;
    end else if (tx_wr) begin
      tx_hold  <= tx_data;
      tx_valid <= 1'b1;
    end
  end

  // Frame / bit engine: shifters, bit counter and output pulses.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      txsh        <= 8'h00;
      rxsh        <= 8'h00;
      bitcnt      <= 3'd0;
      rx_data     <= 8'h00;
      rx_first    <= 1'b0;
      rx_stb      <= 1'b0;
      stb_pend    <= 1'b0;
      first_flag  <= 1'b1;
      tx_need     <= 1'b0;
      tx_underrun <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_stb      <= stb_pend;
      stb_pend    <= 1'b0;
      tx_need     <= 1'b0;
      tx_underrun <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= ~cs_s;
      if (do_load) begin
        txsh        <= ld_byte;
        tx_underrun <= ld_under;
        tx_need     <= 1'b1;
      end
      unique case (1'b1)
        cs_rise: begin
          frame_end <= 1'b1;
          bitcnt    <= 3'd0;
        end
        cs_fall: begin
          first_flag <= 1'b1;
          bitcnt     <= 3'd0;
        end
        ck_rise: begin
          rxsh   <= {rxsh[6:0], do_s};
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            rx_data    <= {rxsh[6:0], do_s};
            rx_first   <= first_flag;
            stb_pend   <= 1'b1;
            first_flag <= 1'b0;
          end
        end
        ck_fall: begin
          if (bitcnt != 3'd0)
            txsh <= {txsh[6:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_link.sv
// tb_spi_slave_link: directed SPI mode-0 master bench for spi_slave_link.
// spick runs at fclk/6; outputs sampled on the falling fclk edge.
module tb_spi_slave_link;

  logic       fclk = 1'b0;
  logic       rst_n;
  logic       spics_n;
  logic       spick;
  logic       spido;
  logic       spidi;
  logic [7:0] rx_data;
  logic       rx_stb;
  logic       rx_first;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_need;
  logic       tx_underrun;
  logic       frame_end;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] rxq[$];
  logic       rfq[$];
  int fe_cnt = 0;
  int need_cnt = 0;
  int und_cnt = 0;

  always #5 fclk = ~fclk;

  spi_slave_link #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .fclk(fclk), .rst_n(rst_n),
    .spics_n(spics_n), .spick(spick), .spido(spido), .spidi(spidi),
    .rx_data(rx_data), .rx_stb(rx_stb), .rx_first(rx_first),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_need(tx_need),
    .tx_underrun(tx_underrun), .frame_end(frame_end), .busy(busy)
  );

  always @(negedge fclk) begin
    if (rst_n) begin
      if (rx_stb) begin
        rxq.push_back(rx_data);
        rfq.push_back(rx_first);
      end
      if (frame_end) fe_cnt++;
      if (tx_need) need_cnt++;
      if (tx_underrun) und_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic xfer(input logic [7:0] m, input int n,
                      output logic [7:0] s);
    s = 8'h00;
    for (int j = 0; j < n; j++) begin
      spido = m[7-j];
      repeat (3) @(negedge fclk);
      s[7-j] = spidi;
      spick = 1'b1;
      repeat (3) @(negedge fclk);
      spick = 1'b0;
    end
  endtask

  task automatic cs_low();
    spics_n = 1'b0;
    repeat (4) @(negedge fclk);
  endtask

  task automatic cs_high();
    repeat (3) @(negedge fclk);
    spics_n = 1'b1;
    repeat (6) @(negedge fclk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge fclk);
    checks++;
    if (spidi !== 1'b1) begin
      errors++; $display("FAIL reset_spidi got %b want 1", spidi);
    end
    checks++;
    if ({rx_stb, tx_need, tx_underrun, frame_end, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b want 00000",
               {rx_stb, tx_need, tx_underrun, frame_end, busy});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_rx_data got %h want 00", rx_data);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge fclk);
  endtask

  task automatic test_basic();
    logic [7:0] s0, s1;
    int q0, fe0, nd0;
    q0 = rxq.size(); fe0 = fe_cnt; nd0 = need_cnt;
    tx_data = 8'h81; tx_wr = 1'b1;
    @(negedge fclk);
    tx_wr = 1'b0;
    repeat (2) @(negedge fclk);
    cs_low();
    checks++;
    if (need_cnt - nd0 !== 1) begin
      errors++; $display("FAIL basic_need got %0d want 1", need_cnt - nd0);
    end
    tx_data = 8'h42; tx_wr = 1'b1;
    @(negedge fclk);
    tx_wr = 1'b0;
    xfer(8'hA5, 8, s0);
    xfer(8'h3C, 8, s1);
    cs_high();
    checks++;
    if (s0 !== 8'h81 || s1 !== 8'h42) begin
      errors++; $display("FAIL basic_miso got %h %h want 81 42", s0, s1);
    end
    checks++;
    if (rxq.size() - q0 !== 2) begin
      errors++; $display("FAIL basic_rx_cnt got %0d want 2", rxq.size() - q0);
    end else begin
      checks++;
      if (rxq[q0] !== 8'hA5 || rfq[q0] !== 1'b1) begin
        errors++;
        $display("FAIL basic_rx0 got %h/%b want a5/1", rxq[q0], rfq[q0]);
      end
      checks++;
      if (rxq[q0+1] !== 8'h3C || rfq[q0+1] !== 1'b0) begin
        errors++;
        $display("FAIL basic_rx1 got %h/%b want 3c/0", rxq[q0+1], rfq[q0+1]);
      end
    end
    checks++;
    if (fe_cnt - fe0 !== 1) begin
      errors++; $display("FAIL basic_frame_end got %0d want 1", fe_cnt - fe0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL basic_busy_idle got %b want 0", busy);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] s0, s1;
    int un0;
    un0 = und_cnt;
    cs_low();
    checks++;
    if (und_cnt - un0 !== 1) begin
      errors++; $display("FAIL under_csfall got %0d want 1", und_cnt - un0);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL under_busy got %b want 1", busy);
    end
    xfer(8'h00, 8, s0);
    xfer(8'h00, 8, s1);
    cs_high();
    checks++;
    if (s0 !== 8'hFF || s1 !== 8'hFF) begin
      errors++; $display("FAIL under_miso got %h %h want ff ff", s0, s1);
    end
    // CS fall, byte boundary and the load after the last byte.
    checks++;
    if (und_cnt - un0 !== 3) begin
      errors++; $display("FAIL under_cnt got %0d want 3", und_cnt - un0);
    end
  endtask

  task automatic test_partial();
    logic [7:0] s;
    int q0, fe0;
    q0 = rxq.size(); fe0 = fe_cnt;
    cs_low();
    xfer(8'hF0, 5, s);
    cs_high();
    checks++;
    if (rxq.size() !== q0) begin
      errors++; $display("FAIL partial_no_stb got %0d want 0", rxq.size() - q0);
    end
    checks++;
    if (fe_cnt - fe0 !== 1) begin
      errors++; $display("FAIL partial_fe got %0d want 1", fe_cnt - fe0);
    end
    cs_low();
    xfer(8'h11, 8, s);
    cs_high();
    checks++;
    if (rxq.size() - q0 !== 1) begin
      errors++; $display("FAIL partial_next_cnt got %0d want 1", rxq.size() - q0);
    end else begin
      checks++;
      if (rxq[q0] !== 8'h11 || rfq[q0] !== 1'b1) begin
        errors++;
        $display("FAIL partial_next got %h/%b want 11/1", rxq[q0], rfq[q0]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [7:0] s0, s1;
    int un0;
    un0 = und_cnt;
    spics_n = 1'b0;
    repeat (2) @(negedge fclk);
    tx_data = 8'h5A; tx_wr = 1'b1;
    @(negedge fclk);
    tx_wr = 1'b0;
    repeat (2) @(negedge fclk);
    checks++;
    if (und_cnt !== un0) begin
      errors++; $display("FAIL bypass_under got %0d want 0", und_cnt - un0);
    end
    xfer(8'h00, 8, s0);
    xfer(8'h00, 8, s1);
    cs_high();
    checks++;
    if (s0 !== 8'h5A) begin
      errors++; $display("FAIL bypass_miso got %h want 5a", s0);
    end
    checks++;
    if (s1 !== 8'hFF || und_cnt - un0 !== 2) begin
      errors++;
      $display("FAIL bypass_cleared got %h/%0d want ff/2", s1, und_cnt - un0);
    end
  endtask

  task automatic test_midreset();
    logic [7:0] s;
    int q0;
    cs_low();
    xfer(8'hC3, 4, s);
    rst_n = 1'b0;
    repeat (2) @(negedge fclk);
    checks++;
    if ({spidi, busy, rx_stb, tx_need, rx_data} !== {4'b1000, 8'h00}) begin
      errors++;
      $display("FAIL midreset_outs got %b%b%b%b/%h want 1000/00",
               spidi, busy, rx_stb, tx_need, rx_data);
    end
    spics_n = 1'b1; spick = 1'b0; spido = 1'b0;
    repeat (3) @(negedge fclk);
    rst_n = 1'b1;
    repeat (4) @(negedge fclk);
    q0 = rxq.size();
    cs_low();
    xfer(8'h77, 8, s);
    cs_high();
    checks++;
    if (rxq.size() - q0 !== 1) begin
      errors++; $display("FAIL midreset_cnt got %0d want 1", rxq.size() - q0);
    end else begin
      checks++;
      if (rxq[q0] !== 8'h77 || rfq[q0] !== 1'b1) begin
        errors++;
        $display("FAIL midreset_rx got %h/%b want 77/1", rxq[q0], rfq[q0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    int q0;
    q0 = rxq.size();
    cs_low();
    for (int b = 0; b < 32; b++) xfer(8'(b), 8, s);
    cs_high();
    checks++;
    if (rxq.size() - q0 !== 32) begin
      errors++; $display("FAIL b2b_cnt got %0d want 32", rxq.size() - q0);
    end else begin
      for (int b = 0; b < 32; b++) begin
        checks++;
        if (rxq[q0+b] !== 8'(b) || rfq[q0+b] !== (b == 0)) begin
          errors++;
          $display("FAIL b2b_byte%0d got %h/%b want %h/%b", b,
                   rxq[q0+b], rfq[q0+b], 8'(b), (b == 0));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; spics_n = 1'b1; spick = 1'b0; spido = 1'b0;
    tx_data = 8'h00; tx_wr = 1'b0;
    test_reset();
    test_basic();
    test_underrun();
    test_partial();
    test_bypass();
    test_midreset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_link.md
Name: spi_slave_link

Overview:
SPI mode-0 slave byte engine, the target end of the FPGA's SPI master links. It is clocked entirely by fclk: spics_n, spick and spido are oversampled through synchronizers. The block deserializes MOSI bytes into rx strobes and serializes a host-supplied tx byte stream onto MISO. It is used on the AVR–FPGA serial link and as a bench/loopback target for the SD master.

Parameters:
SYNC_STAGES, 2, synchronizer depth for spics_n/spick/spido (min 2).
IDLE_BYTE, 8'hFF, byte shifted out when no tx byte is pending (underrun).

Ports:
fclk  input  1  system clock; all state on posedge.
rst_n  input  1  asynchronous active-low reset.
spics_n  input  1  SPI chip select, active low, asynchronous to fclk.
spick  input  1  SPI clock, idle low, asynchronous; max frequency fclk/6.
spido  input  1  MOSI data, sampled on spick rising.
spidi  output  1  MISO data, changes after spick falling.
rx_data  output  8  last completed received byte, MSB first on wire.
rx_stb  output  1  one-fclk pulse: rx_data is valid.
rx_first  output  1  qualifies rx_stb: the byte is the first in its frame.
tx_data  input  8  next byte to transmit.
tx_wr  input  1  one-cycle write of tx_data into the holding register.
tx_need  output  1  one-fclk pulse: holding register consumed, supply the next byte.
tx_underrun  output  1  one-fclk pulse: IDLE_BYTE loaded because no byte was pending.
frame_end  output  1  one-fclk pulse on synchronized spics_n rising.
busy  output  1  synchronized spics_n low.

Behaviour:
- Reset (async): sync chains to idle (cs=1, sck=0, do=0); shifters, bitcnt, rx_data = 0; tx_valid=0; spidi=1; all pulses 0; busy=0; first_flag=1.
- Edge detect: compare the last two synced samples. Event latency is SYNC_STAGES+1 fclk from the pin.
- CS inactive: bitcnt=0, spidi=1, no shifting. spick edges are ignored.
- Load operation (used at CS fall and at byte boundaries):
  - If tx_wr is asserted in the same cycle, txsh<=tx_data (bypass), no underrun.
  - Else if tx_valid, txsh<=tx_hold.
  - Else txsh<=IDLE_BYTE and tx_underrun pulses.
  - Always clear tx_valid and pulse tx_need.
- CS falling: perform load; first_flag<=1; bitcnt<=0. spidi=txsh[7] is valid before the first rising edge.
- spick rising (CS active): rxsh<={rxsh[6:0],spido_s}; bitcnt<=bitcnt+1 (3-bit wrap).
  - When bitcnt was 7: rx_data<={rxsh[6:0],spido_s} and rx_first<=first_flag in that cycle; rx_stb pulses the following cycle; first_flag<=0.
- spick falling (CS active):
  - bitcnt==0 (byte just completed): perform load.
  - Otherwise txsh<={txsh[6:0],1'b0}.
  - spidi=txsh[7] combinationally from the register.
- tx_wr outside a load: tx_hold<=tx_data, tx_valid<=1. A second write before consumption overwrites; no error.
- CS rising: frame_end pulses; bitcnt<=0; a partial rx byte is discarded (no rx_stb); tx_valid and tx_hold are preserved.
- CS rising coincident with a spick edge: CS wins and the edge is ignored.
- rx_data holds its value until the next completed byte.
- rx_stb and tx_need can coincide; both are independent pulses.

Test Plan:
1. Frame CS low, MOSI 0xA5,0x3C, tx_wr 0x81 pre-CS and 0x42 on tx_need -> rx_stb twice with rx_data 0xA5 (rx_first=1) then 0x3C (rx_first=0); MISO 0x81,0x42; frame_end once.
2. No tx_wr across a 2-byte frame -> MISO 0xFF,0xFF; tx_underrun pulses at CS fall and at the byte boundary.
3. CS raised after 5 clocks of 0xF0 -> no rx_stb, frame_end=1. The next frame's first byte 0x11 is reported with rx_first=1 and rx_data=0x11.
4. tx_wr=1 with tx_data=0x5A in the exact cycle of a load -> MISO 0x5A; no tx_underrun; tx_valid=0 afterwards.
5. rst_n low mid-byte (bit 4) then released, then a new frame of 0x77 -> outputs at reset values during reset; 0x77 received cleanly with rx_first=1.
6. spick at fclk/6 with 32 back-to-back bytes of incrementing pattern 0x00..0x1F -> all 32 rx_stb delivered in order, none missing or duplicated.
